// File: rtl/fb_ring_ctrl_pkg.sv
// Shared definitions for the frame-buffer ring controller.
package fb_ring_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RESET,
    S_INIT,
    S_INIT_WAIT,
    S_PREFILL,
    S_STREAM,
    S_ERR
  } state_t;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

  // Relative age of a ready buffer: 0 = newest. At most four buffers exist,
  // so two bits keep ready buffers strictly ordered.
  localparam int AGE_W = 2;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

endpackage

// File: rtl/fb_ring_ctrl_if.sv
// Handshake/status bundle between the ring controller and its datapath.
interface fb_ring_ctrl_if #(
  parameter int NUM_FB = 3,
  parameter int SEL_W  = 2
);
  logic              init_done;
  logic              init_start;
  logic              wr_frame_done;
  logic              rd_frame_done;
  logic              rdempty_cam;
  logic [NUM_FB-1:0] avl_ready;
  logic              wrfull_adv;
  logic [NUM_FB-1:0] rd_data_valid;
  logic              HDMI_TX_DE;
  logic              rdempty_adv;
  logic [NUM_FB-1:0] wr_en_n;
  logic [NUM_FB-1:0] rd_en_n;
  logic              rdreq_cam;
  logic              wrreq_adv;
  logic              rdreq_adv;
  logic [SEL_W-1:0]  wr_sel;
  logic [SEL_W-1:0]  rd_sel;
  logic              streaming;
  logic              init_err;
  logic [15:0]       drop_cnt;

  modport master (
    input  init_done, wr_frame_done, rd_frame_done, rdempty_cam, avl_ready,
           wrfull_adv, rd_data_valid, HDMI_TX_DE, rdempty_adv,
    output init_start, wr_en_n, rd_en_n, rdreq_cam, wrreq_adv, rdreq_adv,
           wr_sel, rd_sel, streaming, init_err, drop_cnt
  );

  modport slave (
    output init_done, wr_frame_done, rd_frame_done, rdempty_cam, avl_ready,
           wrfull_adv, rd_data_valid, HDMI_TX_DE, rdempty_adv,
    input  init_start, wr_en_n, rd_en_n, rdreq_cam, wrreq_adv, rdreq_adv,
           wr_sel, rd_sel, streaming, init_err, drop_cnt
  );
endinterface

// File: rtl/fb_pick_next.sv
// Chooses the writer's next buffer: lowest-index free buffer that is not the
// reader's, else the oldest ready buffer (which then gets overwritten).
import fb_ring_ctrl_pkg::*;

module fb_pick_next #(
  parameter int NUM_FB = 3,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_FB-1:0]            ready,
  input  logic [NUM_FB-1:0][AGE_W-1:0] age,
  input  logic [SEL_W-1:0]             rd_sel,
  output logic [SEL_W-1:0]             nxt,
  output logic                         hit
);
  logic             found;
  logic [AGE_W-1:0] best;

  // Free buffer first; the just-written frame is ready, so it is skipped
  // unless it is the only candidate left.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    best  = '0;
    hit   = 1'b0;
    for (int i = 0; i < NUM_FB; i++)
      if (!found && !ready[i] && SEL_W'(i) != rd_sel) begin
        found = 1'b1;
        nxt   = SEL_W'(i);
      end
    if (!found)
      for (int i = 0; i < NUM_FB; i++)
        if (ready[i] && SEL_W'(i) != rd_sel && (!found || age[i] > best)) begin
          found = 1'b1;
          best  = age[i];
          nxt   = SEL_W'(i);
        end
    for (int i = 0; i < NUM_FB; i++)
      if (SEL_W'(i) == nxt) hit = ready[i];
  end
endmodule

// File: rtl/fb_ring_ctrl.sv
// Frame-buffer ring controller: init sequencing, writer/reader buffer
// rotation with newest-frame display, and per-buffer enable steering.
import fb_ring_ctrl_pkg::*;

module fb_ring_ctrl #(
  parameter int NUM_FB   = 3,
  parameter int SEL_W    = 2,
  parameter int INIT_TMO = 1048575
) (
  input logic           clk,
  input logic           reset,
  fb_ring_ctrl_if.master bus
);
  state_t                     state, state_nx;
  logic [31:0]                tmo_cnt;
  logic [SEL_W-1:0]           wr_sel, rd_sel, rd_nx, wr_pick;
  logic [NUM_FB-1:0]          ready, rdy_w, rdy_r, rdy_nx;
  logic [NUM_FB-1:0][AGE_W-1:0] age, age_w;
  logic [AGE_W-1:0]           rd_age;
  logic [15:0]                drop_cnt;
  logic                       wr_ev, take_rd, rd_hit, pick_hit, wr_act, rd_act;
  logic [NUM_FB-1:0]          wr_en_n, rd_en_n;
  logic                       rdreq_cam, wrreq_adv;

  assign wr_act  = (state == S_PREFILL) || (state == S_STREAM);
  assign rd_act  = (state == S_STREAM);
  assign wr_ev   = wr_act && bus.wr_frame_done;
  // The first completed frame is handed straight to the reader.
  assign take_rd = (state == S_PREFILL && bus.wr_frame_done) ||
                   (state == S_STREAM && bus.rd_frame_done);

  // Next-state logic for the init/stream sequencer.
  always_comb begin
    state_nx = state;
    case (state)
      S_RESET:     state_nx = S_INIT;
      S_INIT:      state_nx = S_INIT_WAIT;
      S_INIT_WAIT: if (bus.init_done) state_nx = S_PREFILL;
                   else if (tmo_cnt == 32'(INIT_TMO - 1)) state_nx = S_ERR;
      S_PREFILL:   if (bus.wr_frame_done) state_nx = S_STREAM;
      default:     ;
    endcase
  end

  // Write completion first (mark newest), then the reader claims the newest.
  always_comb begin
    rdy_w  = ready;
    age_w  = age;
    rdy_r  = '0;
    rd_nx  = rd_sel;
    rd_hit = 1'b0;
    rd_age = '1;
    for (int i = 0; i < NUM_FB; i++) begin
      if (wr_ev && SEL_W'(i) == wr_sel) begin
        rdy_w[i] = 1'b1;
        age_w[i] = '0;
      end else if (wr_ev && ready[i] && age[i] != AGE_MAX) begin
        age_w[i] = age[i] + 1'b1;
      end
    end
    for (int i = 0; i < NUM_FB; i++)
      if (take_rd && rdy_w[i] && (!rd_hit || age_w[i] < rd_age)) begin
        rd_hit = 1'b1;
        rd_age = age_w[i];
        rd_nx  = SEL_W'(i);
      end
    for (int i = 0; i < NUM_FB; i++)
      rdy_r[i] = rdy_w[i] && !(rd_hit && SEL_W'(i) == rd_nx);
  end

  fb_pick_next #(.NUM_FB(NUM_FB), .SEL_W(SEL_W)) u_pick (
    .ready (rdy_r),
    .age   (age_w),
    .rd_sel(rd_nx),
    .nxt   (wr_pick),
    .hit   (pick_hit)
  );

  // A ready frame the writer moves onto is lost, so it leaves the ready set.
  always_comb begin
    rdy_nx = rdy_r;
    for (int i = 0; i < NUM_FB; i++)
      if (wr_ev && SEL_W'(i) == wr_pick) rdy_nx[i] = 1'b0;
  end

  // State, timeout counter, buffer bookkeeping and drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_RESET;
      tmo_cnt  <= '0;
      wr_sel   <= '0;
      rd_sel   <= SEL_W'(NUM_FB - 1);
      ready    <= '0;
      age      <= '0;
      drop_cnt <= '0;
    end else begin
      state   <= state_nx;
      tmo_cnt <= (state == S_INIT_WAIT) ? tmo_cnt + 32'd1 : '0;
      rd_sel  <= rd_nx;
      ready   <= rdy_nx;
      age     <= age_w;
      if (wr_ev) begin
        wr_sel <= wr_pick;
        if (pick_hit && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Enable steering, combinational from registered state and selects.
  always_comb begin
    wr_en_n   = {NUM_FB{DEASSERT_L}};
    rd_en_n   = {NUM_FB{DEASSERT_L}};
    rdreq_cam = DEASSERT_H;
    wrreq_adv = DEASSERT_H;
    for (int i = 0; i < NUM_FB; i++) begin
      if (wr_act && !bus.rdempty_cam && SEL_W'(i) == wr_sel) begin
        wr_en_n[i] = ASSERT_L;
        rdreq_cam  = bus.avl_ready[i];
      end
      if (rd_act && !bus.wrfull_adv && SEL_W'(i) == rd_sel) begin
        rd_en_n[i] = ASSERT_L;
        wrreq_adv  = bus.rd_data_valid[i];
      end
    end
  end

  assign bus.wr_en_n    = wr_en_n;
  assign bus.rd_en_n    = rd_en_n;
  assign bus.rdreq_cam  = rdreq_cam;
  assign bus.wrreq_adv  = wrreq_adv;
  assign bus.rdreq_adv  = rd_act ? (bus.HDMI_TX_DE & ~bus.rdempty_adv) : DEASSERT_H;
  assign bus.init_start = (state == S_INIT) ? ASSERT_H : DEASSERT_H;
  assign bus.streaming  = rd_act;
  assign bus.init_err   = (state == S_ERR);
  assign bus.wr_sel     = wr_sel;
  assign bus.rd_sel     = rd_sel;
  assign bus.drop_cnt   = drop_cnt;
endmodule

// File: doc/fb_ring_ctrl.md
FB_RING_CTRL -- requirements
Module: fb_ring_ctrl

Interface
REQ-001 SHALL have parameters: NUM_FB, default 3, frame-buffer count, legal 2..4; SEL_W, default 2, index width, >= clog2(NUM_FB); INIT_TMO, default 1048575, init_done timeout in cycles.
REQ-002 SHALL have ports: clk  in  1  sole clock; reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: init_done  in  1  components initialised; init_start  out  1  one-cycle init kick.
REQ-004 SHALL have ports: wr_frame_done  in  1  writer finished a frame into wr_sel buffer (1-cycle pulse); rd_frame_done  in  1  reader finished a frame from rd_sel (1-cycle pulse).
REQ-005 SHALL have ports: rdempty_cam  in  1; avl_ready  in  NUM_FB; wrfull_adv  in  1; rd_data_valid  in  NUM_FB; HDMI_TX_DE  in  1; rdempty_adv  in  1.
REQ-006 SHALL have ports: wr_en_n  out  NUM_FB  active-low per-buffer write enable; rd_en_n  out  NUM_FB  active-low per-buffer read enable; rdreq_cam, wrreq_adv, rdreq_adv  out  1  active-high FIFO strobes.
REQ-007 SHALL have ports: wr_sel, rd_sel  out  SEL_W  current buffer indices; streaming  out  1; init_err  out  1; drop_cnt  out  16  frames overwritten before display.

Function
REQ-008 SHALL implement states S_RESET, S_INIT, S_INIT_WAIT, S_PREFILL, S_STREAM, S_ERR; S_RESET->S_INIT->S_INIT_WAIT unconditionally, one cycle each.
REQ-009 SHALL assert init_start for exactly the cycle in S_INIT.
REQ-010 SHALL leave S_INIT_WAIT to S_PREFILL when init_done=1; after INIT_TMO cycles without init_done SHALL enter S_ERR, set init_err=1, hold all enables deasserted until reset.
REQ-011 SHALL in S_PREFILL write only (read path idle); first wr_frame_done SHALL set rd_sel to the completed buffer, advance wr_sel, and enter S_STREAM the next cycle.
REQ-012 SHALL keep a ready flag and age per buffer; wr_frame_done SHALL mark wr_sel ready-newest and advance wr_sel to the lowest-index buffer that is neither rd_sel nor the newest ready buffer, else to the oldest ready buffer not equal to rd_sel.
REQ-013 SHALL increment drop_cnt (saturating at 16'hFFFF) whenever wr_sel advances onto a ready, unread buffer; with NUM_FB=2 every overwrite counts.
REQ-014 SHALL on rd_frame_done set rd_sel to the newest ready buffer and clear its ready flag; if none ready SHALL keep rd_sel (repeat frame).
REQ-015 SHALL when wr_frame_done and rd_frame_done coincide process write first, so the reader takes the just-completed frame.
REQ-016 SHALL guarantee wr_sel != rd_sel in every cycle of S_STREAM.
REQ-017 SHALL in S_STREAM, when rdempty_cam=0, drive wr_en_n[wr_sel]=0 and others 1, with rdreq_cam = avl_ready[wr_sel]; else all wr_en_n=1, rdreq_cam=0.
REQ-018 SHALL in S_STREAM, when wrfull_adv=0, drive rd_en_n[rd_sel]=0 and others 1, with wrreq_adv = rd_data_valid[rd_sel]; else all rd_en_n=1, wrreq_adv=0.
REQ-019 SHALL drive rdreq_adv = HDMI_TX_DE & ~rdempty_adv in S_STREAM, 0 otherwise.
REQ-020 SHALL keep enable/strobe outputs combinational from registered state/select (zero latency); selects update one cycle after the done pulse.
REQ-021 SHALL drive streaming=1 only in S_STREAM, and force all enables deasserted outside S_STREAM (S_PREFILL excepted for write path).

Reset
REQ-022 SHALL on reset=0, asynchronously: state=S_RESET, init_start=0, wr_sel=0, rd_sel=NUM_FB-1, all ready flags 0, drop_cnt=0, init_err=0, wr_en_n/rd_en_n all 1, strobes 0.
REQ-023 SHALL on reset mid-frame abandon the frame with no drop count; operation restarts at S_INIT.

Structure
REQ-024 SHALL place state encoding and ASSERT_L/DEASSERT_L/ASSERT_H/DEASSERT_H constants in the shared project package.
REQ-025 SHALL implement next-buffer selection (REQ-012) in one sub-module fb_pick_next, purely combinational.

Verification
REQ-026 Reset release, init_done at cycle 10 -> init_start pulse at cycle 2, S_PREFILL at cycle 11, init_err=0.
REQ-027 init_done never asserted, INIT_TMO=100 -> init_err=1 after 100 wait cycles; all enables stay deasserted.
REQ-028 NUM_FB=3, write 3 frames, no rd_frame_done -> wr_sel cycles avoiding rd_sel; drop_cnt=1 after third write.
REQ-029 NUM_FB=3, simultaneous wr_frame_done/rd_frame_done -> rd_sel equals the just-written buffer next cycle; wr_sel != rd_sel.
REQ-030 NUM_FB=2, rd_frame_done with no ready frame -> rd_sel unchanged; wrfull_adv=1 -> rd_en_n=2'b11, wrreq_adv=0.
REQ-031 Reset asserted mid-S_STREAM -> outputs at REQ-022 values same cycle, drop_cnt=0.
